// File: rtl/bcd_tick_counter.sv
// -----------------------------------------------------------------------------
// bcd_tick_counter
//
// Two-digit BCD counter (00..99) that feeds the HEX1/HEX0 seven-segment
// decoders. A prescaler divides CLOCK_50 into a count tick. The counter
// supports a synchronous load from switches, an enable/hold input and
// one-cycle pulses that flag each counted step and each wrap.
//
// Optional feature macro: BCD_DOWN_EN
//   defined   : DOWN selects the count direction (1 = down, 00 -> 99 wraps).
//   undefined : the counter counts up only; DOWN is accepted but ignored.
//
// Parameters
//   TICK_DIV  enabled clock cycles per count tick (>= 1)
//
// Ports
//   CLOCK_50  in   sole clock, rising edge
//   RST       in   asynchronous active-high reset
//   EN        in   count enable; prescaler and digits hold while low
//   LOAD      in   synchronous load strobe (wins over a coincident tick)
//   LD_VAL    in   load value, [7:4] tens, [3:0] ones; nibbles > 9 clamp to 9
//   DOWN      in   count direction (only with BCD_DOWN_EN)
//   DIG1      out  tens digit, registered
//   DIG0      out  ones digit, registered
//   TICK      out  high in the cycle a counted value first appears
//   WRAP      out  high in the cycle the wrapped value first appears
// -----------------------------------------------------------------------------
module bcd_tick_counter #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       CLOCK_50,
  input  logic       RST,
  input  logic       EN,
  input  logic       LOAD,
  input  logic [7:0] LD_VAL,
  input  logic       DOWN,
  output logic [3:0] DIG1,
  output logic [3:0] DIG0,
  output logic       TICK,
  output logic       WRAP
);

  // A divide-by-1 prescaler still needs a 1-bit register to keep the
  // compare well formed; it simply never leaves 0.
  localparam int            PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_pcnt;
  logic [3:0]    r_dig1;
  logic [3:0]    r_dig0;
  logic          r_tick;
  logic          r_wrap;

  logic          w_tick;
  logic [3:0]    w_ld1;
  logic [3:0]    w_ld0;
  logic [3:0]    w_up1;
  logic [3:0]    w_up0;
  logic          w_up_wrap;
  logic [3:0]    w_nxt1;
  logic [3:0]    w_nxt0;
  logic          w_nxt_wrap;

  assign w_tick = EN && (r_pcnt == PMAX);

  // Load clamp: any non-BCD nibble saturates at 9.
  assign w_ld1 = (LD_VAL[7:4] > 4'd9) ? 4'd9 : LD_VAL[7:4];
  assign w_ld0 = (LD_VAL[3:0] > 4'd9) ? 4'd9 : LD_VAL[3:0];

  // Per-nibble BCD increment.
  always_comb begin
    w_up1     = r_dig1;
    w_up0     = r_dig0 + 4'd1;
    w_up_wrap = 1'b0;
    if (r_dig0 >= 4'd9) begin
      w_up0 = 4'd0;
      if (r_dig1 >= 4'd9) begin
        w_up1     = 4'd0;
        w_up_wrap = 1'b1;
      end else begin
        w_up1 = r_dig1 + 4'd1;
      end
    end
  end

`ifdef BCD_DOWN_EN
  logic [3:0] w_dn1;
  logic [3:0] w_dn0;
  logic       w_dn_wrap;

  // Per-nibble BCD decrement.
  always_comb begin
    w_dn1     = r_dig1;
    w_dn0     = r_dig0 - 4'd1;
    w_dn_wrap = 1'b0;
    if (r_dig0 == 4'd0) begin
      w_dn0 = 4'd9;
      if (r_dig1 == 4'd0) begin
        w_dn1     = 4'd9;
        w_dn_wrap = 1'b1;
      end else begin
        w_dn1 = r_dig1 - 4'd1;
      end
    end
  end

  assign w_nxt1     = DOWN ? w_dn1     : w_up1;
  assign w_nxt0     = DOWN ? w_dn0     : w_up0;
  assign w_nxt_wrap = DOWN ? w_dn_wrap : w_up_wrap;
`else
  // Up-only build: the direction input is kept on the port list for
  // board compatibility but has no internal load.
  logic w_unused_down;
  assign w_unused_down = DOWN;

  assign w_nxt1     = w_up1;
  assign w_nxt0     = w_up0;
  assign w_nxt_wrap = w_up_wrap;
`endif

  // Priority: reset > load > tick > hold. TICK/WRAP are registered so they
  // line up with the digit update they describe.
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      r_pcnt <= '0;
      r_dig1 <= 4'd0;
      r_dig0 <= 4'd0;
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
    end else if (LOAD) begin
      r_pcnt <= '0;
      r_dig1 <= w_ld1;
      r_dig0 <= w_ld0;
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
    end else if (w_tick) begin
      r_pcnt <= '0;
      r_dig1 <= w_nxt1;
      r_dig0 <= w_nxt0;
      r_tick <= 1'b1;
      r_wrap <= w_nxt_wrap;
    end else begin
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
      if (EN) begin
        r_pcnt <= r_pcnt + 1'b1;
      end
    end
  end

  assign DIG1 = r_dig1;
  assign DIG0 = r_dig0;
  assign TICK = r_tick;
  assign WRAP = r_wrap;

endmodule

// File: doc/bcd_tick_counter.md
# bcd_tick_counter

Two-digit BCD counter (00–99) that drives the pair of hex seven-segment decoders on the board. A parameterised prescaler turns `CLOCK_50` into a count tick. The block supports synchronous load from switches, enable/hold, and wrap detection. `DIG1`/`DIG0` connect directly to the 4-bit inputs of the `HEX1`/`HEX0` decoder instances, replacing the raw `SW[7:4]`/`SW[3:0]` feed.

## Interface
- `TICK_DIV`, default 50_000_000: enabled clock cycles per count tick (1 Hz at 50 MHz); legal range ≥ 1.
- `CLOCK_50`  in  1  sole clock; all state changes on its rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `EN`  in  1  count enable; prescaler and digits hold while low.
- `LOAD`  in  1  synchronous load strobe.
- `LD_VAL`  in  8  load value: `[7:4]` tens, `[3:0]` ones, BCD.
- `DOWN`  in  1  count direction: 1 = down. Honoured only with `BCD_DOWN_EN`.
- `DIG1`  out  4  tens digit, 0–9, registered.
- `DIG0`  out  4  ones digit, 0–9, registered.
- `TICK`  out  1  one-cycle pulse, registered; high in the cycle a counted value first appears.
- `WRAP`  out  1  one-cycle pulse, registered; high in the cycle the wrapped value (00 up / 99 down) first appears.

## Operation
- Prescaler `pcnt`, width `$clog2(TICK_DIV)` (minimum 1 bit).
  - `tick_w = EN && (pcnt == TICK_DIV-1)`.
  - When `EN=1`: `pcnt` increments each cycle and returns to 0 when `tick_w` is high.
  - When `EN=0`: `pcnt` holds its value.
  - `TICK_DIV=1`: `tick_w = EN` every cycle.
- Priority per edge: `RST` > `LOAD` > `tick_w` > hold.
- `LOAD=1`:
  - `DIG1`/`DIG0` take `LD_VAL`.
  - Any nibble > 9 clamps to 9 (`8'hAF` loads 99; `8'h3C` loads 39).
  - `pcnt` clears to 0. `TICK`=0 and `WRAP`=0 on the following cycle.
  - Works regardless of `EN`.
- Count up, on `tick_w` (`DOWN` low or macro absent):
  - Ones 0–8 → +1.
  - Ones 9 → ones 0 and tens +1.
  - 99 → 00 with `WRAP`.
- Count down, on `tick_w` (`DOWN` high, macro present):
  - Ones 1–9 → −1.
  - Ones 0 → ones 9 and tens −1.
  - 00 → 99 with `WRAP`.
- Digits never leave 0–9. Arithmetic is per-nibble BCD; there is no binary intermediate.
- `DOWN` is sampled only on the `tick_w` edge; changing it between ticks has no effect.

## Timing
- Reset values: `DIG1`=0, `DIG0`=0, `TICK`=0, `WRAP`=0, `pcnt`=0.
  - Outputs go to these values asynchronously on `RST` assertion, mid-count included.
- First tick after reset release with `EN=1` held: new value is visible `TICK_DIV` rising edges after the first edge with `RST` low.
- Latency:
  - `LOAD` → digits: 1 edge.
  - `tick_w` → digits/`TICK`/`WRAP`: 1 edge, all update on the same edge.
- `TICK` and `WRAP` are never high for more than one consecutive cycle unless `TICK_DIV=1`.
- `LOAD` coincident with `tick_w`: the load wins, no count, no `WRAP`, prescaler cleared.
- `EN` falling mid-prescale: `pcnt` freezes; on `EN` rising it resumes from the frozen value, with no tick lost or added.

## Configuration
- `BCD_DOWN_EN`:
  - Defined: `DOWN` selects direction as above; the down-wrap 00→99 raises `WRAP`.
  - Undefined: `DOWN` is unconnected internally (port remains) and the counter counts up only. No down-count logic is synthesised.

## Test plan
- Reset release, `TICK_DIV=4`, `EN=1`: `DIG1:DIG0` = 0:0 for the first 3 edges, 0:1 with `TICK`=1 at edge 4, 0:2 at edge 8.
- `LOAD` with `LD_VAL=8'h98`, `EN=1`, up count: 98 → 99 after 4 edges → 00 after 8 edges. `WRAP`=1 for exactly that one cycle; `TICK`=1 at both steps.
- `BCD_DOWN_EN` defined, load 00, `DOWN=1`: after 4 edges 99 with `WRAP`=1; after 4 more, 98. Same stimulus with the macro undefined: 01, `WRAP`=0.
- Load `8'hAF`, then `8'h3C`: digits read 99, then 39. `LOAD` asserted on the same edge as `tick_w`: loaded value appears, `TICK`=0, next tick comes 4 edges later.
- `EN` low for 10 cycles when `pcnt`=2: digits and `pcnt` hold. After `EN` returns high, the next tick arrives exactly 2 edges later.
- `RST` pulsed between edges while at 57 with `pcnt`=3: outputs read 00 and `TICK`/`WRAP` read 0 before the next edge. Counting restarts per the first scenario.
